seg_scan_ctrl: RTL

Parametrised multiplexed 7-segment display controller for the Basys3 CPU top level. Each transfer accepts a new value over a valid/ready handshake. The value is shown either as hex nibbles or as unsigned binary converted to decimal by a sequential double-dabble engine. The block adds leading-zero blanking, per-digit decimal points, an overflow indication, anode dead time and 16-level brightness PWM, and drives common-anode digits with active-low anodes and segments.

---
 rtl/seg_scan_ctrl.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_ctrl
//  Description : Multiplexed common-anode 7-segment display controller.
//                Accepts a value over a valid/ready handshake and shows it as
//                hex nibbles or as decimal (sequential double-dabble). Adds
//                leading-zero blanking, per-digit decimal points, an overflow
//                dash display, anode dead time and 16-level brightness PWM.
//                Anodes and segments are active-low.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 25000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] din,
    input  logic                    din_valid,
    output logic                    din_ready,
    input  logic                    mode_dec,
    input  logic                    lz_blank,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic [3:0]              bright,
    output logic [NUM_DIGITS-1:0]   seg_an,
    output logic [7:0]              seg_seg,
    output logic                    overflow
);

    // ------------------------------------------------------------------------
    // Derived widths and typed constants
    // ------------------------------------------------------------------------
    localparam int c_W      = 4 * NUM_DIGITS;
    // Two spare BCD digits guarantee room for the largest W-bit value, so
    // anything landing above digit NUM_DIGITS-1 is a genuine overflow.
    localparam int c_BCD_D  = NUM_DIGITS + 2;
    localparam int c_BCD_W  = 4 * c_BCD_D;
    localparam int c_SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_CNT_W  = $clog2(c_W + 1);

    localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(SCAN_DIV - 1);
    localparam logic [c_SLOT_W-1:0] c_BLANK     = c_SLOT_W'(BLANK_CYCLES);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_LAST  = c_CNT_W'(c_W - 1);

    // ------------------------------------------------------------------------
    // FSM encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic                           w_accept;

    // Staging registers (captured on accept)
    logic [c_W-1:0]                 r_bin;
    logic                           r_stg_dec;
    logic                           r_stg_lz;
    logic [NUM_DIGITS-1:0]          r_stg_dp;

    // Double-dabble engine
    logic [c_BCD_W-1:0]             r_bcd;
    logic [c_BCD_W-1:0]             w_bcd_adj;
    logic [c_CNT_W-1:0]             r_bit_cnt;

    // Committed display state
    logic [NUM_DIGITS-1:0][3:0]     r_disp;
    logic [NUM_DIGITS-1:0]          r_dp;
    logic                           r_lz;
    logic                           r_overflow;

    // Scan / PWM
    logic [c_SLOT_W-1:0]            r_slot_cnt;
    logic [c_IDX_W-1:0]             r_idx;
    logic [3:0]                     r_pwm_cnt;
    logic [3:0]                     r_bright_q;

    // Output stage
    logic [NUM_DIGITS-1:0]          w_blank;
    logic                           w_seen_nz;
    logic [7:0]                     w_seg_nxt;
    logic [NUM_DIGITS-1:0]          w_an_nxt;
    logic [NUM_DIGITS-1:0]          r_seg_an;
    logic [7:0]                     r_seg_seg;

    // ------------------------------------------------------------------------
    // Hex nibble to {g..a} segment pattern, active-low
    // ------------------------------------------------------------------------
    function automatic logic [6:0] f_seg7(input logic [3:0] d);
        logic [6:0] v;
        case (d)
            4'h0: v = 7'h40;
            4'h1: v = 7'h79;
            4'h2: v = 7'h24;
            4'h3: v = 7'h30;
            4'h4: v = 7'h19;
            4'h5: v = 7'h12;
            4'h6: v = 7'h02;
            4'h7: v = 7'h78;
            4'h8: v = 7'h00;
            4'h9: v = 7'h10;
            4'hA: v = 7'h08;
            4'hB: v = 7'h03;
            4'hC: v = 7'h46;
            4'hD: v = 7'h21;
            4'hE: v = 7'h06;
            default: v = 7'h0E;
        endcase
        return v;
    endfunction

    assign din_ready = (r_state == S_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: hex skips straight to COMMIT, decimal runs W shifts
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (din_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = mode_dec ? S_CONV : S_COMMIT;
                end
            end
            S_CONV: begin
                if (r_bit_cnt == c_CNT_LAST) begin
                    w_state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Add-3 correction applied to every BCD digit that is 5 or more
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < c_BCD_D; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Capture staging data on accept, then shift binary into BCD MSB first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin     <= '0;
            r_stg_dec <= 1'b0;
            r_stg_lz  <= 1'b0;
            r_stg_dp  <= '0;
            r_bcd     <= '0;
            r_bit_cnt <= '0;
        end else if (w_accept) begin
            r_bin     <= din;
            r_stg_dec <= mode_dec;
            r_stg_lz  <= lz_blank;
            r_stg_dp  <= dp_mask;
            r_bcd     <= '0;
            r_bit_cnt <= '0;
        end else if (r_state == S_CONV) begin
            r_bcd     <= {w_bcd_adj[c_BCD_W-2:0], r_bin[c_W-1]};
            r_bin     <= {r_bin[c_W-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    // Atomic update of everything the scanner displays
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp     <= '0;
            r_dp       <= '0;
            r_lz       <= 1'b0;
            r_overflow <= 1'b0;
        end else if (r_state == S_COMMIT) begin
            r_disp     <= r_stg_dec ? r_bcd[c_W-1:0] : r_bin;
            r_dp       <= r_stg_dp;
            r_lz       <= r_stg_lz;
            r_overflow <= r_stg_dec & (|r_bcd[c_BCD_W-1:c_W]);
        end
    end

    // Slot timer, digit index, free-running PWM counter and brightness sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_cnt <= '0;
            r_idx      <= '0;
            r_pwm_cnt  <= '0;
            r_bright_q <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
            if (r_slot_cnt == c_SLOT_LAST) begin
                r_slot_cnt <= '0;
                r_bright_q <= bright;
                r_idx      <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_slot_cnt <= r_slot_cnt + 1'b1;
            end
        end
    end

    // Leading-zero blanking: walk from the MSD down until a non-zero digit
    always_comb begin
        w_blank   = '0;
        w_seen_nz = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (r_disp[i] != 4'd0) begin
                w_seen_nz = 1'b1;
            end
            if (r_lz && !w_seen_nz && (i != 0)) begin
                w_blank[i] = 1'b1;
            end
        end
    end

    // Segment and anode pattern for the digit currently being scanned
    always_comb begin
        w_seg_nxt = 8'hFF;
        w_an_nxt  = '1;
        if (r_overflow) begin
            w_seg_nxt = 8'hBF;
        end else begin
            w_seg_nxt[7]   = ~r_dp[r_idx];
            w_seg_nxt[6:0] = w_blank[r_idx] ? 7'h7F : f_seg7(r_disp[r_idx]);
        end
        if ((r_slot_cnt >= c_BLANK) && (r_pwm_cnt <= r_bright_q)) begin
            w_an_nxt[r_idx] = 1'b0;
        end
    end

    // Registered pin drivers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_an  <= '1;
            r_seg_seg <= 8'hFF;
        end else begin
            r_seg_an  <= w_an_nxt;
            r_seg_seg <= w_seg_nxt;
        end
    end

    assign seg_an   = r_seg_an;
    assign seg_seg  = r_seg_seg;
    assign overflow = r_overflow;

endmodule
`default_nettype wire
